// File: rtl/fault_mem_pkg.sv
// Shared fault-type encoding for the faulty-RAM model.
package fault_mem_pkg;
  localparam int FT_W = 3;

  typedef enum logic [FT_W-1:0] {
    FT_NONE    = 3'd0,
    FT_SAF0    = 3'd1,
    FT_SAF1    = 3'd2,
    FT_TF_UP   = 3'd3,
    FT_TF_DOWN = 3'd4,
    FT_CFIN    = 3'd5
  } fault_type_e;
endpackage

// File: rtl/fault_mem_inject.sv
// Combinational fault rules: turns an ideal access into the faulty one and flags
// whether any bit differs from ideal-RAM behaviour.
module fault_mem_inject
  import fault_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                          wr,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [DATA_WIDTH-1:0]         old_word,
  input  logic [DATA_WIDTH-1:0]         new_word,
  input  logic [FT_W-1:0]               fault_type,
  input  logic [ADDR_WIDTH-1:0]         victim_addr,
  input  logic [$clog2(DATA_WIDTH)-1:0] victim_bit,
  input  logic [ADDR_WIDTH-1:0]         aggr_addr,
  input  logic [$clog2(DATA_WIDTH)-1:0] aggr_bit,
  output logic [DATA_WIDTH-1:0]         store_word,
  output logic [DATA_WIDTH-1:0]         rd_force_mask,
  output logic [DATA_WIDTH-1:0]         rd_force_val,
  output logic [DATA_WIDTH-1:0]         victim_flip_mask,
  output logic                          hit
);
  logic [DATA_WIDTH-1:0] vmask;
  logic [DATA_WIDTH-1:0] amask;
  logic                  is_victim;
  logic                  is_aggr;
  logic                  v_old;
  logic                  v_new;
  logic                  a_toggle;
  logic                  cfin_self;

  assign vmask     = DATA_WIDTH'(1) << victim_bit;
  assign amask     = DATA_WIDTH'(1) << aggr_bit;
  assign is_victim = (addr == victim_addr);
  assign is_aggr   = (addr == aggr_addr);
  assign v_old     = |(old_word & vmask);
  assign v_new     = |(new_word & vmask);
  assign a_toggle  = |((old_word ^ new_word) & amask);
  // An aggressor that is its own victim cell cannot couple to itself.
  assign cfin_self = (aggr_addr == victim_addr) && (aggr_bit == victim_bit);

  always_comb begin
    store_word       = new_word;
    rd_force_mask    = '0;
    rd_force_val     = '0;
    victim_flip_mask = '0;
    hit              = 1'b0;
    case (fault_type_e'(fault_type))
      FT_SAF0: if (is_victim) begin
        if (wr) begin
          store_word = new_word & ~vmask;
          hit        = v_new;
        end else begin
          rd_force_mask = vmask;
          hit           = v_old;
        end
      end
      FT_SAF1: if (is_victim) begin
        if (wr) begin
          store_word = new_word | vmask;
          hit        = ~v_new;
        end else begin
          rd_force_mask = vmask;
          rd_force_val  = vmask;
          hit           = ~v_old;
        end
      end
      FT_TF_UP: if (wr && is_victim && !v_old && v_new) begin
        store_word = new_word & ~vmask;
        hit        = 1'b1;
      end
      FT_TF_DOWN: if (wr && is_victim && v_old && !v_new) begin
        store_word = new_word | vmask;
        hit        = 1'b1;
      end
      FT_CFIN: if (wr && is_aggr && a_toggle && !cfin_self) begin
        if (is_victim) store_word = new_word ^ vmask;
        else           victim_flip_mask = vmask;
        hit = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/fault_mem_multi.sv
// Single-port sync RAM with one runtime-selectable injected fault and a registered
// command stage. Define FAULT_LOG_EN to enable fault_hit / fault_cnt logging.
module fault_mem_multi
  import fault_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write_read,
  input  logic [ADDR_WIDTH-1:0]         address,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [FT_W-1:0]               fault_type,
  input  logic [ADDR_WIDTH-1:0]         victim_addr,
  input  logic [$clog2(DATA_WIDTH)-1:0] victim_bit,
  input  logic [ADDR_WIDTH-1:0]         aggr_addr,
  input  logic [$clog2(DATA_WIDTH)-1:0] aggr_bit,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          rdata_valid,
  output logic                          fault_hit,
  output logic [CNT_WIDTH-1:0]          fault_cnt
);
  localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH+1)'(CAPACITY);

  logic [DATA_WIDTH-1:0] mem [CAPACITY];

  logic                  vld_p1;
  logic                  wr_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;
  logic                  rd_vld_p2;
  logic [DATA_WIDTH-1:0] rd_data_p2;

  logic                  in_range_p1;
  logic                  victim_in_range;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] store_word;
  logic [DATA_WIDTH-1:0] rd_force_mask;
  logic [DATA_WIDTH-1:0] rd_force_val;
  logic [DATA_WIDTH-1:0] victim_flip_mask;
  logic                  inj_hit;
  logic                  flip_en;
  logic                  hit_eff;

  assign in_range_p1     = ({1'b0, addr_p1} < CAP);
  assign victim_in_range = ({1'b0, victim_addr} < CAP);
  assign old_word        = in_range_p1 ? mem[addr_p1] : '0;

  fault_mem_inject #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_inject (
    .wr              (wr_p1),
    .addr            (addr_p1),
    .old_word        (old_word),
    .new_word        (wdata_p1),
    .fault_type      (fault_type),
    .victim_addr     (victim_addr),
    .victim_bit      (victim_bit),
    .aggr_addr       (aggr_addr),
    .aggr_bit        (aggr_bit),
    .store_word      (store_word),
    .rd_force_mask   (rd_force_mask),
    .rd_force_val    (rd_force_val),
    .victim_flip_mask(victim_flip_mask),
    .hit             (inj_hit)
  );

  // A coupling flip onto an out-of-range victim changes nothing, so it is not a hit.
  assign flip_en = vld_p1 && wr_p1 && in_range_p1 && (|victim_flip_mask) && victim_in_range;
  assign hit_eff = vld_p1 && in_range_p1 && inj_hit && (~|victim_flip_mask || victim_in_range);

  // Stage 1 (E0): command capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      wr_p1    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1   <= 1'b1;
      wr_p1    <= write_read;
      addr_p1  <= address;
      wdata_p1 <= wdata;
    end
  end

  // Stage 2 (E1): array access
  always_ff @(posedge clk) begin
    if (vld_p1 && wr_p1 && in_range_p1) mem[addr_p1] <= store_word;
    if (flip_en) mem[victim_addr] <= mem[victim_addr] ^ victim_flip_mask;
  end

  always_ff @(posedge clk) begin
    if (vld_p1 && !wr_p1)
      rd_data_p2 <= in_range_p1 ? ((old_word & ~rd_force_mask) | (rd_force_val & rd_force_mask)) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_vld_p2 <= 1'b0;
    else     rd_vld_p2 <= vld_p1 && !wr_p1;
  end

  // Stage 3 (E2): read return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= rd_vld_p2;
      if (rd_vld_p2) rdata <= rd_data_p2;
    end
  end

`ifdef FAULT_LOG_EN
  logic hit_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_p2    <= 1'b0;
      fault_hit <= 1'b0;
      fault_cnt <= '0;
    end else begin
      hit_p2    <= hit_eff;
      fault_hit <= hit_p2;
      if (hit_p2 && !(&fault_cnt)) fault_cnt <= fault_cnt + 1'b1;
    end
  end
`else
  logic unused_hit;
  assign unused_hit = hit_eff;
  assign fault_hit  = 1'b0;
  assign fault_cnt  = '0;
`endif
endmodule

// File: tb/tb_fault_mem_multi.sv
// Directed bench for fault_mem_multi: each fault type, range boundary, back-to-back
// write/read and mid-flight reset, with hand-computed expectations.
module tb_fault_mem_multi;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int CAP = 12;
  localparam int CW  = 16;
`ifdef FAULT_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          write_read;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic [2:0]    fault_type;
  logic [AW-1:0] victim_addr;
  logic [2:0]    victim_bit;
  logic [AW-1:0] aggr_addr;
  logic [2:0]    aggr_bit;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          fault_hit;
  logic [CW-1:0] fault_cnt;

  int checks  = 0;
  int errors  = 0;
  int exp_cnt = 0;

  fault_mem_multi #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CAPACITY  (CAP),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .write_read (write_read),
    .address    (address),
    .wdata      (wdata),
    .fault_type (fault_type),
    .victim_addr(victim_addr),
    .victim_bit (victim_bit),
    .aggr_addr  (aggr_addr),
    .aggr_bit   (aggr_bit),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .fault_hit  (fault_hit),
    .fault_cnt  (fault_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Idle command: write to an address beyond CAPACITY, which the RAM ignores.
  task automatic idle();
    write_read = 1'b1;
    address    = 4'hF;
    wdata      = 8'h00;
  endtask

  task automatic cfg(input logic [2:0] ft, input logic [AW-1:0] va, input logic [2:0] vb,
                     input logic [AW-1:0] aa, input logic [2:0] ab);
    fault_type  = ft;
    victim_addr = va;
    victim_bit  = vb;
    aggr_addr   = aa;
    aggr_bit    = ab;
  endtask

  task automatic op(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [DW-1:0] exp_rd, input bit exp_hit, input string tag);
    @(negedge clk);
    write_read = wr;
    address    = a;
    wdata      = d;
    @(negedge clk);
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    if (LOG && exp_hit) exp_cnt++;
    if (!wr) chk({tag, ".rdata"}, 32'(rdata), 32'(exp_rd));
    chk({tag, ".valid"}, 32'(rdata_valid), 32'(!wr));
    chk({tag, ".hit"}, 32'(fault_hit), 32'(LOG && exp_hit));
    chk({tag, ".cnt"}, 32'(fault_cnt), 32'(exp_cnt));
    if (!wr) begin
      @(posedge clk);
      #1;
      chk({tag, ".pulse"}, 32'(rdata_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cfg(3'd0, 4'd0, 3'd0, 4'd0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rdata", 32'(rdata), 32'd0);
    chk("rst.valid", 32'(rdata_valid), 32'd0);
    chk("rst.hit", 32'(fault_hit), 32'd0);
    chk("rst.cnt", 32'(fault_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Ideal RAM, plus pre-initialising cells used later as aggressor/victim
    op(1'b1, 4'd3, 8'hA5, 8'h00, 1'b0, "none.w3");
    op(1'b0, 4'd3, 8'h00, 8'hA5, 1'b0, "none.r3");
    op(1'b1, 4'd9, 8'h00, 8'h00, 1'b0, "none.w9");
    op(1'b1, 4'd1, 8'h00, 8'h00, 1'b0, "none.w1");
    op(1'b1, 4'd10, 8'h00, 8'h00, 1'b0, "none.w10");
    op(1'b1, 4'd11, 8'h3C, 8'h00, 1'b0, "none.w11");
    op(1'b1, 4'd13, 8'h55, 8'h00, 1'b0, "oor.w13");
    op(1'b0, 4'd13, 8'h00, 8'h00, 1'b0, "oor.r13");
    op(1'b0, 4'd11, 8'h00, 8'h3C, 1'b0, "last.r11");

    cfg(3'd1, 4'd5, 3'd1, 4'd0, 3'd0);
    op(1'b1, 4'd5, 8'hFF, 8'h00, 1'b1, "saf0.w5");
    op(1'b0, 4'd5, 8'h00, 8'hFD, 1'b0, "saf0.r5");
    op(1'b1, 4'd6, 8'hFF, 8'h00, 1'b0, "saf0.w6");
    op(1'b0, 4'd6, 8'h00, 8'hFF, 1'b0, "saf0.r6");

    cfg(3'd4, 4'd2, 3'd1, 4'd0, 3'd0);
    op(1'b1, 4'd2, 8'h02, 8'h00, 1'b0, "tfd.w2a");
    op(1'b1, 4'd2, 8'h00, 8'h00, 1'b1, "tfd.w2b");
    op(1'b0, 4'd2, 8'h00, 8'h02, 1'b0, "tfd.r2");
    cfg(3'd4, 4'd9, 3'd1, 4'd0, 3'd0);
    op(1'b1, 4'd9, 8'h00, 8'h00, 1'b0, "tfd.w9a");
    op(1'b1, 4'd9, 8'h02, 8'h00, 1'b0, "tfd.w9b");
    op(1'b0, 4'd9, 8'h00, 8'h02, 1'b0, "tfd.r9");

    cfg(3'd3, 4'd4, 3'd0, 4'd0, 3'd0);
    op(1'b1, 4'd4, 8'h00, 8'h00, 1'b0, "tfu.w4a");
    op(1'b1, 4'd4, 8'h01, 8'h00, 1'b1, "tfu.w4b");
    op(1'b0, 4'd4, 8'h00, 8'h00, 1'b0, "tfu.r4a");
    op(1'b1, 4'd4, 8'h00, 8'h00, 1'b0, "tfu.w4c");
    op(1'b0, 4'd4, 8'h00, 8'h00, 1'b0, "tfu.r4b");

    cfg(3'd5, 4'd8, 3'd0, 4'd1, 3'd7);
    op(1'b1, 4'd8, 8'h00, 8'h00, 1'b0, "cfin.w8");
    op(1'b1, 4'd1, 8'h00, 8'h00, 1'b0, "cfin.w1a");
    op(1'b1, 4'd1, 8'h80, 8'h00, 1'b1, "cfin.w1b");
    op(1'b0, 4'd8, 8'h00, 8'h01, 1'b0, "cfin.r8a");
    op(1'b1, 4'd1, 8'h80, 8'h00, 1'b0, "cfin.w1c");
    op(1'b0, 4'd8, 8'h00, 8'h01, 1'b0, "cfin.r8b");
    op(1'b0, 4'd1, 8'h00, 8'h80, 1'b0, "cfin.r1");

    cfg(3'd5, 4'd10, 3'd0, 4'd10, 3'd7);
    op(1'b1, 4'd10, 8'h80, 8'h00, 1'b1, "cfsame.w10");
    op(1'b0, 4'd10, 8'h00, 8'h81, 1'b0, "cfsame.r10");
    cfg(3'd5, 4'd10, 3'd0, 4'd10, 3'd0);
    op(1'b1, 4'd10, 8'h00, 8'h00, 1'b0, "cfoff.w10");
    op(1'b0, 4'd10, 8'h00, 8'h00, 1'b0, "cfoff.r10");

    cfg(3'd2, 4'd11, 3'd0, 4'd0, 3'd0);
    op(1'b0, 4'd11, 8'h00, 8'h3D, 1'b1, "saf1.r11a");
    cfg(3'd2, 4'd11, 3'd2, 4'd0, 3'd0);
    op(1'b0, 4'd11, 8'h00, 8'h3C, 1'b0, "saf1.r11b");
    cfg(3'd2, 4'd6, 3'd7, 4'd0, 3'd0);
    op(1'b1, 4'd6, 8'h00, 8'h00, 1'b1, "saf1.w6");
    op(1'b0, 4'd6, 8'h00, 8'h80, 1'b0, "saf1.r6");

    // Back-to-back write then read of the same word
    cfg(3'd0, 4'd0, 3'd0, 4'd0, 3'd0);
    @(negedge clk);
    write_read = 1'b1;
    address    = 4'd7;
    wdata      = 8'h5A;
    @(negedge clk);
    write_read = 1'b0;
    @(negedge clk);
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("b2b.rdata", 32'(rdata), 32'h5A);
    chk("b2b.valid", 32'(rdata_valid), 32'd1);
    @(posedge clk);
    #1;
    chk("b2b.pulse", 32'(rdata_valid), 32'd0);

    // Reset lands between a read's E1 and E2
    @(negedge clk);
    write_read = 1'b0;
    address    = 4'd3;
    @(negedge clk);
    idle();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst.rdata", 32'(rdata), 32'd0);
    chk("mrst.valid", 32'(rdata_valid), 32'd0);
    chk("mrst.cnt", 32'(fault_cnt), 32'd0);
    @(posedge clk);
    #1;
    chk("mrst.e2valid", 32'(rdata_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    @(posedge clk);
    #1;
    chk("mrst.post", 32'(rdata_valid), 32'd0);
    op(1'b0, 4'd7, 8'h00, 8'h5A, 1'b0, "keep.r7");
    op(1'b0, 4'd3, 8'h00, 8'hA5, 1'b0, "keep.r3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
